// File: rtl/prio_enc_rr.sv
// prio_enc_rr: registered N-input priority encoder with fixed-priority and
// round-robin modes. One decision per enabled cycle. The index, one-hot grant
// and valid flag are all flops, so no input reaches an output combinationally.
module prio_enc_rr #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] x,
  input  logic         en,
  input  logic         mode,
  output logic [W-1:0] y,
  output logic [N-1:0] g,
  output logic         v
);

  localparam logic [N-1:0] ONE_HOT_0 = {{(N-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] LAST_IDX  = W'(N - 1);

  logic [W-1:0] y_r;
  logic [N-1:0] g_r;
  logic         v_r;
  logic [W-1:0] ptr_r;

  logic         any_s;
  logic [W-1:0] fix_idx_s;
  logic [W-1:0] rr_idx_s;
  logic         rr_found_s;
  logic [W-1:0] grant_idx_s;
  logic [W-1:0] ptr_nxt_s;

  // Fixed priority: the last set bit seen in an ascending scan is the highest index.
  always_comb begin
    any_s     = |x;
    fix_idx_s = '0;
    for (int i = 0; i < N; i++) begin
      if (x[i]) begin
        fix_idx_s = W'(i);
      end else begin
        fix_idx_s = fix_idx_s;
      end
    end
  end

  // Round-robin: scan from ptr upward with an explicit wrap at N, so non-power-of-two N works.
  always_comb begin
    rr_idx_s   = '0;
    rr_found_s = 1'b0;
    for (int k = 0; k < N; k++) begin
      int j;
      j = int'(ptr_r) + k;
      if (j >= N) begin
        j = j - N;
      end else begin
        j = j;
      end
      if (!rr_found_s && x[j]) begin
        rr_found_s = 1'b1;
        rr_idx_s   = W'(j);
      end else begin
        rr_found_s = rr_found_s;
      end
    end
  end

  // Select the winner for the active mode and form the pointer that follows it.
  always_comb begin
    if (mode) begin
      grant_idx_s = rr_idx_s;
    end else begin
      grant_idx_s = fix_idx_s;
    end
    if (rr_idx_s == LAST_IDX) begin
      ptr_nxt_s = '0;
    end else begin
      ptr_nxt_s = rr_idx_s + W'(1);
    end
  end

  // Decision register: reset beats enable, en=0 holds everything, ptr moves only on RR grants.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_r   <= '0;
      g_r   <= '0;
      v_r   <= 1'b0;
      ptr_r <= '0;
    end else if (en) begin
      if (!any_s) begin
        y_r <= '0;
        g_r <= '0;
        v_r <= 1'b0;
      end else begin
        y_r <= grant_idx_s;
        g_r <= ONE_HOT_0 << grant_idx_s;
        v_r <= 1'b1;
        if (mode) begin
          ptr_r <= ptr_nxt_s;
        end else begin
          ptr_r <= ptr_r;
        end
      end
    end else begin
      y_r   <= y_r;
      g_r   <= g_r;
      v_r   <= v_r;
      ptr_r <= ptr_r;
    end
  end

  assign y = y_r;
  assign g = g_r;
  assign v = v_r;

endmodule

// File: tb/tb_prio_enc_rr.sv
// Bench for prio_enc_rr: an N=4 and an N=5 instance share control inputs.
// A behavioural model (modulo-arithmetic search) is compared every cycle,
// and directed vectors carry hand-computed literal expectations.
`timescale 1ns/1ps
module tb_prio_enc_rr;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       mode = 1'b0;
  logic [4:0] x = 5'b00000;

  logic [1:0] y4;
  logic [3:0] g4;
  logic       v4;
  logic [2:0] y5;
  logic [4:0] g5;
  logic       v5;

  int checks = 0;
  int failures = 0;
  logic armed = 1'b0;

  typedef struct packed {
    logic       v;
    logic [7:0] y;
    logic [7:0] g;
    logic [7:0] ptr;
  } m_t;

  m_t m4 = '0;
  m_t m5 = '0;

  prio_enc_rr #(.N(4)) dut4 (
    .clk(clk), .rst(rst), .x(x[3:0]), .en(en), .mode(mode),
    .y(y4), .g(g4), .v(v4)
  );

  prio_enc_rr #(.N(5)) dut5 (
    .clk(clk), .rst(rst), .x(x), .en(en), .mode(mode),
    .y(y5), .g(g5), .v(v5)
  );

  always #5 clk = ~clk;

  // One enabled decision of an n-input encoder, from the rules, with modulo wrap.
  function automatic m_t mstep(input int n, input logic [7:0] xv, input logic md, input m_t cur);
    m_t r;
    int idx;
    r = cur;
    idx = -1;
    if (xv == 8'd0) begin
      r.v = 1'b0;
      r.y = 8'd0;
      r.g = 8'd0;
      return r;
    end
    if (!md) begin
      for (int i = n - 1; i >= 0; i--)
        if (idx < 0 && xv[i]) idx = i;
    end else begin
      for (int k = 0; k < n; k++)
        if (idx < 0 && xv[(int'(cur.ptr) + k) % n]) idx = (int'(cur.ptr) + k) % n;
      r.ptr = 8'((idx + 1) % n);
    end
    r.v = 1'b1;
    r.y = 8'(idx);
    r.g = 8'(1 << idx);
    return r;
  endfunction

  // Reference state, advanced on the same edge as the DUTs.
  always @(posedge clk) begin
    if (rst) begin
      m4 <= '0;
      m5 <= '0;
      armed <= 1'b1;
    end else if (en) begin
      m4 <= mstep(4, {4'b0000, x[3:0]}, mode, m4);
      m5 <= mstep(5, {3'b000, x}, mode, m5);
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (armed) begin
      chk("model4_v", int'(v4), int'(m4.v));
      chk("model4_y", int'(y4), int'(m4.y));
      chk("model4_g", int'(g4), int'(m4.g));
      chk("model5_v", int'(v5), int'(m5.v));
      chk("model5_y", int'(y5), int'(m5.y));
      chk("model5_g", int'(g5), int'(m5.g));
    end
  end

  task automatic cyc(input logic r, input logic e, input logic md, input logic [4:0] xv);
    @(negedge clk);
    rst = r;
    en = e;
    mode = md;
    x = xv;
    @(posedge clk);
    #1;
  endtask

  task automatic exp4(input string nm, input int ev, input int ey, input int eg);
    chk({nm, "_v"}, int'(v4), ev);
    chk({nm, "_y"}, int'(y4), ey);
    chk({nm, "_g"}, int'(g4), eg);
  endtask

  task automatic exp5(input string nm, input int ev, input int ey, input int eg);
    chk({nm, "_v"}, int'(v5), ev);
    chk({nm, "_y"}, int'(y5), ey);
    chk({nm, "_g"}, int'(g5), eg);
  endtask

  initial begin
    // Reset state
    cyc(1'b1, 1'b0, 1'b0, 5'b00000);
    exp4("reset4", 0, 0, 4'b0000);
    exp5("reset5", 0, 0, 5'b00000);

    // Fixed priority
    cyc(1'b0, 1'b1, 1'b0, 5'b00000); exp4("fix_0000", 0, 0, 4'b0000);
    cyc(1'b0, 1'b1, 1'b0, 5'b01011); exp4("fix_1011", 1, 3, 4'b1000);
    cyc(1'b0, 1'b1, 1'b0, 5'b00101); exp4("fix_0101", 1, 2, 4'b0100);
    cyc(1'b0, 1'b1, 1'b0, 5'b01110); exp4("fix_1110", 1, 3, 4'b1000);

    // Round-robin from reset with x=1011 held
    cyc(1'b1, 1'b0, 1'b0, 5'b00000);
    cyc(1'b0, 1'b1, 1'b1, 5'b01011); exp4("rr1", 1, 0, 4'b0001);
    cyc(1'b0, 1'b1, 1'b1, 5'b01011); exp4("rr2", 1, 1, 4'b0010);
    cyc(1'b0, 1'b1, 1'b1, 5'b01011); exp4("rr3", 1, 3, 4'b1000);
    cyc(1'b0, 1'b1, 1'b1, 5'b01011); exp4("rr4", 1, 0, 4'b0001);
    cyc(1'b0, 1'b1, 1'b1, 5'b01011); exp4("rr5", 1, 1, 4'b0010);

    // Hold with en=0 while x changes; then resume from ptr=2
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 5'b01111); exp4("hold", 1, 1, 4'b0010);
    end
    cyc(1'b0, 1'b1, 1'b1, 5'b01111); exp4("resume", 1, 2, 4'b0100);

    // Mode switch keeps ptr
    cyc(1'b0, 1'b1, 1'b1, 5'b00001); exp4("ms_rr0", 1, 0, 4'b0001);
    cyc(1'b0, 1'b1, 1'b0, 5'b00011); exp4("ms_fix", 1, 1, 4'b0010);
    cyc(1'b0, 1'b1, 1'b1, 5'b00011); exp4("ms_rr1", 1, 1, 4'b0010);
    cyc(1'b0, 1'b1, 1'b1, 5'b00011); exp4("ms_rr2", 1, 0, 4'b0001);

    // Empty request in RR: outputs clear, ptr holds (ptr=1 so 0011 grants 1)
    cyc(1'b0, 1'b1, 1'b1, 5'b00000); exp4("rr_empty", 0, 0, 4'b0000);
    cyc(1'b0, 1'b1, 1'b1, 5'b00011); exp4("rr_after_empty", 1, 1, 4'b0010);

    // Reset mid-run with ptr=3, reset beats en
    cyc(1'b0, 1'b1, 1'b1, 5'b00100); exp4("pre_rst", 1, 2, 4'b0100);
    cyc(1'b1, 1'b1, 1'b1, 5'b01111); exp4("mid_rst", 0, 0, 4'b0000);
    cyc(1'b0, 1'b1, 1'b1, 5'b01111); exp4("post_rst", 1, 0, 4'b0001);

    // N=5 wrap from 4 to 0
    cyc(1'b1, 1'b0, 1'b0, 5'b00000);
    cyc(1'b0, 1'b1, 1'b1, 5'b10001); exp5("n5_a", 1, 0, 5'b00001);
    cyc(1'b0, 1'b1, 1'b1, 5'b10001); exp5("n5_b", 1, 4, 5'b10000);
    cyc(1'b0, 1'b1, 1'b1, 5'b10001); exp5("n5_c", 1, 0, 5'b00001);
    cyc(1'b0, 1'b1, 1'b1, 5'b10001); exp5("n5_d", 1, 4, 5'b10000);

    // N=5 fixed priority picks index 4, and a sweep of patterns for the model
    cyc(1'b0, 1'b1, 1'b0, 5'b11010); exp5("n5_fix", 1, 4, 5'b10000);
    for (int i = 0; i < 40; i++) begin
      cyc(1'b0, ((i % 5) != 3) ? 1'b1 : 1'b0, ((i % 3) != 0) ? 1'b1 : 1'b0, 5'((i * 7 + 3) % 32));
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prio_enc_rr.md
# prio_enc_rr

Parametrised, registered N-input priority encoder. It is the successor to the 4-to-2 combinational encoder: input width is generalised to N, output is registered with a valid flag and a one-hot grant, and a round-robin mode with a rotating priority pointer is added. It sits between request sources and a shared-resource controller and converts a request vector into a registered index, one decision per enabled cycle.

## Interface
- N, 4, number of request inputs (N >= 2; N need not be a power of two)
- W, $clog2(N), width of the encoded index
- clk  input  1  rising-edge clock; the only clock
- rst  input  1  synchronous reset, active-high
- x  input  N  request vector; bit i = request i
- en  input  1  sample strobe; a decision is made only on cycles with en=1
- mode  input  1  0 = fixed priority (highest index wins), 1 = round-robin
- y  output  W  registered index of the granted request
- g  output  N  registered one-hot grant (g == 1<<y when v=1, else 0)
- v  output  1  registered valid: at least one request was present at the last enabled sample

## Operation
- Reset: with rst=1 at a clock edge, y=0, g=0, v=0, and the RR pointer ptr=0. rst overrides en.
- en=0: y, g, v and ptr hold their values. x and mode are ignored.
- en=1 and x=0: v<=0, g<=0, y<=0. ptr holds.
- Fixed mode (mode=0), en=1, x!=0: grant the highest set index i. y<=i, g<=1<<i, v<=1. ptr is not changed.
- RR mode (mode=1), en=1, x!=0: search indices ptr, ptr+1, ... N-1, 0, ... ptr-1 and grant the first set bit i. y<=i, g<=1<<i, v<=1, ptr<=(i==N-1) ? 0 : i+1.
- ptr is internal and W bits wide. It always holds a value in 0..N-1. Wrap-around is explicit, not modulo 2^W, so non-power-of-two N works.
- Changing mode between samples is legal. ptr keeps its value across mode switches and resumes from that value when RR mode is re-entered.
- Width rule: y is zero-extended from index i. Bits of x above N-1 do not exist. No X propagation is allowed: all outputs are defined on every cycle after reset.

## Timing
- Latency is 1 cycle: x/mode/en sampled at edge k appear on y/g/v after edge k.
- Throughput is one decision per cycle. Back-to-back en=1 cycles are legal. The pointer update from edge k is used by the search at edge k+1.
- rst=1 together with en=1: reset wins and the request is dropped.
- Reset mid-operation: after the edge with rst=1, outputs are 0 and the next RR search starts at index 0.
- Outputs are pure flops with no combinational path from inputs to outputs.

## Test plan
- Fixed, N=4: x=4'b0000, then 1011, then 0101, then 1110, each with en=1 for one cycle -> outputs one cycle later: (v=0,y=0,g=0000), (v=1,y=3,g=1000), (v=1,y=2,g=0100), (v=1,y=3,g=1000).
- RR, N=4, after reset, x=4'b1011 held, en=1 for 5 cycles -> y sequence 0,1,3,0,1 and g sequence 0001,0010,1000,0001,0010, with v=1 throughout.
- Hold, RR: after a grant of y=1, drop en for 3 cycles while changing x to 1111 -> y=1 and v=1 held. Re-assert en -> y=2 (ptr was 2).
- Mode switch: in RR, grant y=0 (ptr=1), switch to mode=0 with x=0011 -> y=1. Switch back to mode=1 with x=0011 -> y=1 (ptr still 1), then y=0.
- Reset mid-run: in RR with ptr=3, assert rst together with en=1 and x=1111 -> the next cycle gives y=0, g=0, v=0. Release rst with x=1111 -> y=0.
- N=5 (W=3), RR: x=5'b10001 held -> y alternates 0,4,0,4. ptr wraps from 4 to 0 and never reaches 5..7.
